// File: rtl/alloc_pkg.sv
// Shared sizing and types for the entry allocator slice.
package alloc_pkg;

   localparam int ENTRY_COUNT = 64;
   localparam int IDX_W       = $clog2(ENTRY_COUNT);

   typedef logic [IDX_W-1:0]       entry_idx_t;
   typedef logic [ENTRY_COUNT-1:0] busy_vec_t;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-free-index finder: returns the lowest index whose busy bit is 0.
module priority_encoder #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0]         busy,
   output logic [$clog2(WIDTH)-1:0] index,
   output logic                     valid
);

   localparam int IDX_W = $clog2(WIDTH);

   // NOTE: every output gets a default before the loop so no path leaves a latch.
   always_comb begin
      index = '0;
      valid = 1'b0;
      // Scan downward so the lowest free entry is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!busy[IDX_W'(i)]) begin
            index = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       valid
);

   localparam int PTR_W = $clog2(NUM_REQ);

   int                 slot;
   logic [PTR_W-1:0]   slot_idx;

   always_comb begin
      winner   = '0;
      valid    = 1'b0;
      slot     = 0;
      slot_idx = '0;
      // Walk offsets from far to near so the nearest requester to ptr wins.
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         slot = int'(ptr) + off;
         if (slot >= NUM_REQ) slot = slot - NUM_REQ;
         slot_idx = PTR_W'(slot);
         if (req[slot_idx]) begin
            winner = slot_idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/entry_allocator.sv
// Busy-table allocator: round-robin single-entry grants, releases, flush.
module entry_allocator #(
   parameter int ENTRY_COUNT = alloc_pkg::ENTRY_COUNT,
   parameter int NUM_REQ     = 4,
   localparam int IDX_W      = $clog2(ENTRY_COUNT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   alloc_index,
   input  logic               rel_valid,
   input  logic [IDX_W-1:0]   rel_index,
   input  logic               flush,
   output logic               full,
   output logic [IDX_W:0]     free_count,
   output logic               rel_err
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = IDX_W + 1;

   logic [ENTRY_COUNT-1:0] busy;
   logic [ENTRY_COUNT-1:0] busy_nxt;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       rr_ptr_nxt;
   logic [IDX_W-1:0]       free_index;
   logic                   free_valid;
   logic [PTR_W-1:0]       winner;
   logic                   any_req;
   logic                   grant;
   logic                   rel_legal;
   logic [CNT_W-1:0]       free_count_nxt;

   priority_encoder #(.WIDTH(ENTRY_COUNT)) u_free_finder (
      .busy  (busy),
      .index (free_index),
      .valid (free_valid)
   );

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req    (req),
      .ptr    (rr_ptr),
      .winner (winner),
      .valid  (any_req)
   );

   // Grant is gated by reset too, so nothing is handed out in a reset cycle.
   assign grant       = rst_n & ~flush & free_valid & any_req;
   assign gnt         = grant ? (NUM_REQ'(1) << winner) : '0;
   assign alloc_index = free_index;
   assign full        = rst_n & ~free_valid;
   assign rel_legal   = rel_valid & busy[rel_index];
   assign rr_ptr_nxt  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   // Grant and legal release never name the same entry: one is free, one busy.
   always_comb begin
      busy_nxt = busy;
      if (grant)     busy_nxt[free_index] = 1'b1;
      if (rel_legal) busy_nxt[rel_index]  = 1'b0;
   end

   assign free_count_nxt = free_count - CNT_W'(grant) + CNT_W'(rel_legal);

   // NOTE: busy is a flop vector, not a RAM, so it is cleared by reset like any register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy       <= '0;
         rr_ptr     <= '0;
         free_count <= CNT_W'(ENTRY_COUNT);
         rel_err    <= 1'b0;
      end else if (flush) begin
         busy       <= '0;
         free_count <= CNT_W'(ENTRY_COUNT);
      end else begin
         busy       <= busy_nxt;
         free_count <= free_count_nxt;
         if (grant)                  rr_ptr  <= rr_ptr_nxt;
         if (rel_valid & ~rel_legal) rel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_entry_allocator.sv
// Directed bench with a per-cycle behavioural model of the allocator.
module tb_entry_allocator;
   import alloc_pkg::*;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   entry_idx_t       alloc_index;
   logic             rel_valid;
   entry_idx_t       rel_index;
   logic             flush;
   logic             full;
   logic [IDX_W:0]   free_count;
   logic             rel_err;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   entry_allocator #(.ENTRY_COUNT(ENTRY_COUNT), .NUM_REQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .gnt         (gnt),
      .alloc_index (alloc_index),
      .rel_valid   (rel_valid),
      .rel_index   (rel_index),
      .flush       (flush),
      .full        (full),
      .free_count  (free_count),
      .rel_err     (rel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain array of in-use flags plus a favoured requester.
   bit m_used [ENTRY_COUNT];
   int m_rr;
   bit m_err;

   initial begin : compare
      int  n_free, low_free, win;
      bit  exp_grant;
      @(posedge clk);
      foreach (m_used[i]) m_used[i] = 1'b0;
      m_rr  = 0;
      m_err = 1'b0;
      while (!done) begin
         @(negedge clk);
         n_free   = 0;
         low_free = -1;
         for (int i = ENTRY_COUNT - 1; i >= 0; i--)
            if (!m_used[i]) begin
               n_free++;
               low_free = i;
            end
         win = -1;
         for (int k = N - 1; k >= 0; k--)
            if (req[(m_rr + k) % N]) win = (m_rr + k) % N;
         exp_grant = rst_n && !flush && n_free > 0 && win >= 0;
         check("m_gnt", gnt, exp_grant ? (64'd1 << win) : 64'd0);
         if (exp_grant) check("m_alloc_index", alloc_index, low_free);
         check("m_full", full, rst_n && n_free == 0);
         check("m_free_count", free_count, n_free);
         check("m_rel_err", rel_err, m_err);
         @(posedge clk);
         if (!rst_n) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
            m_rr  = 0;
            m_err = 1'b0;
         end else if (flush) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
         end else begin
            if (rel_valid) begin
               if (m_used[rel_index]) m_used[rel_index] = 1'b0;
               else                   m_err = 1'b1;
            end
            if (exp_grant) begin
               m_used[low_free] = 1'b1;
               m_rr = (win + 1) % N;
            end
         end
      end
   end

   task automatic drive(input logic [N-1:0] r, input logic rv, input int ri, input logic fl);
      req       = r;
      rel_valid = rv;
      rel_index = entry_idx_t'(ri);
      flush     = fl;
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      drive('0, 1'b0, 0, 1'b0);
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] rot [5];
      rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n = 1'b0;
      req = '0; rel_valid = 1'b0; rel_index = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single requester: successive indices from zero.
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 1'b0, 0, 1'b0);
         check("single_gnt", gnt, 4'b0001);
         check("single_idx", alloc_index, i);
         next_cycle();
      end
      drive('0, 1'b0, 0, 1'b0);
      check("single_count", free_count, 61);
      next_cycle();

      // All requesting from pointer 0: grants rotate.
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 1'b0, 0, 1'b0);
         check("rot_gnt", gnt, rot[i]);
         check("rot_idx", alloc_index, i);
         next_cycle();
      end

      // Fill the table, then free 37 and re-allocate it.
      for (int i = 0; i < 59; i++) begin
         drive(4'b1111, 1'b0, 0, 1'b0);
         next_cycle();
      end
      drive(4'b1111, 1'b0, 0, 1'b0);
      check("full_flag", full, 1'b1);
      check("full_count", free_count, 0);
      check("full_gnt", gnt, 4'b0000);
      next_cycle();
      drive(4'b1111, 1'b1, 37, 1'b0);
      check("full_rel_gnt", gnt, 4'b0000);
      next_cycle();
      drive(4'b1111, 1'b0, 0, 1'b0);
      check("refill_full", full, 1'b0);
      check("refill_any_gnt", |gnt, 1'b1);
      check("refill_idx", alloc_index, 37);
      next_cycle();

      // Flush, allocate 0..4, then grant 5 alongside release of 2.
      drive('0, 1'b0, 0, 1'b1);
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         drive(4'b0001, 1'b0, 0, 1'b0);
         next_cycle();
      end
      drive(4'b0001, 1'b1, 2, 1'b0);
      check("both_idx", alloc_index, 5);
      next_cycle();
      drive(4'b0001, 1'b0, 0, 1'b0);
      check("both_count", free_count, 59);
      check("both_reuse_idx", alloc_index, 2);
      next_cycle();

      // Release of a free entry sets the sticky error.
      drive('0, 1'b1, 10, 1'b0);
      next_cycle();
      drive('0, 1'b0, 0, 1'b0);
      check("err_set", rel_err, 1'b1);
      check("err_count", free_count, 58);
      next_cycle();
      for (int i = 0; i < 14; i++) begin
         drive(4'b0001, 1'b0, 0, 1'b0);
         next_cycle();
      end
      drive('0, 1'b0, 0, 1'b0);
      check("err_sticky", rel_err, 1'b1);
      check("pre_flush_count", free_count, 44);
      next_cycle();
      drive(4'b1111, 1'b1, 3, 1'b1);
      check("flush_gnt", gnt, 4'b0000);
      next_cycle();
      drive(4'b1111, 1'b0, 0, 1'b0);
      check("post_flush_count", free_count, 64);
      check("post_flush_idx", alloc_index, 0);
      check("post_flush_err", rel_err, 1'b1);
      next_cycle();

      // Reset mid-stream with everyone requesting.
      rst_n = 1'b0;
      drive(4'b1111, 1'b0, 0, 1'b0);
      check("rst_gnt", gnt, 4'b0000);
      check("rst_full", full, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      drive(4'b1111, 1'b0, 0, 1'b0);
      check("rst_err", rel_err, 1'b0);
      check("rst_count", free_count, 64);
      check("rst_gnt_first", gnt, 4'b0001);
      check("rst_idx", alloc_index, 0);
      next_cycle();

      drive('0, 1'b0, 0, 1'b0);
      next_cycle();
      done = 1'b1;
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/entry_allocator.md
Name: entry_allocator

Overview:
- Shared allocator for a 64-entry tracked resource, such as the physical register file, ROB or RS slots.
- Holds the busy table and arbitrates single-entry allocation requests from NUM_REQ requesters with round-robin fairness.
- Accepts entry releases from commit/writeback and supports a global flush.
- Uses the existing priority_encoder (lowest free index) as its free-slot finder.

Parameters:
- ENTRY_COUNT, 64, number of tracked entries (power of two, >=4).
- NUM_REQ, 4, number of allocation requesters (>=2).
- IDX_W, $clog2(ENTRY_COUNT), entry index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester allocation request, level; held until granted.
- gnt  out  NUM_REQ  one-hot grant; at most one bit set per cycle.
- alloc_index  out  IDX_W  allocated entry index; valid when |gnt.
- rel_valid  in  1  release strobe.
- rel_index  in  IDX_W  entry being released.
- flush  in  1  free all entries.
- full  out  1  no free entry (busy table all ones).
- free_count  out  IDX_W+1  number of free entries, registered.
- rel_err  out  1  sticky: a release targeted an already-free entry.

Behaviour:
- State:
  - busy[ENTRY_COUNT-1:0], where 1 = in use and 0 = free (same polarity as priority_encoder input).
  - rr_ptr[$clog2(NUM_REQ)-1:0], the highest-priority requester.
  - free_count.
  - rel_err.
- Reset (rst_n=0 at an edge):
  - busy=0, rr_ptr=0, free_count=ENTRY_COUNT, rel_err=0.
  - Outputs during and after reset: gnt=0 while rst_n=0, full=0.
  - Reset mid-operation discards all allocations; no grant is issued in a cycle where rst_n=0.
- Free finder: priority_encoder on the registered busy gives free_index/valid combinationally. full = !valid.
- Arbitration (combinational from registered state):
  - The first requester at or after rr_ptr (wrapping modulo NUM_REQ) with req=1 wins.
  - gnt is one-hot to the winner only if valid=1 and flush=0; otherwise gnt=0.
  - alloc_index = free_index, zero-latency: grant and index appear in the same cycle as the request.
  - Requester consumes the index on the edge where its gnt=1 and must drop or re-assert req for a new entry.
- On the edge with a grant:
  - busy[alloc_index] <= 1.
  - rr_ptr <= winner+1 (wrapping at NUM_REQ).
  - rr_ptr is unchanged when there is no grant.
- Release:
  - If rel_valid and busy[rel_index]=1: busy[rel_index] <= 0.
  - If rel_valid and busy[rel_index]=0: no table change, rel_err <= 1 (sticky until reset).
- Simultaneous grant + release:
  - Both apply on the same edge.
  - A released entry is not allocatable until the following cycle, because the finder sees the registered table.
  - Grant and release can never name the same index: the grant targets a free entry, and a legal release targets a busy one.
- free_count update: next = free_count - grant + legal_release, so simultaneous grant and legal release leaves it unchanged.
- Invariant: free_count == popcount(~busy) every cycle. The bench checks this.
- Flush (flush=1 at an edge):
  - busy <= 0, free_count <= ENTRY_COUNT.
  - gnt forced 0 that cycle; a release that cycle is ignored (no rel_err); rr_ptr unchanged.
  - Flush has priority over release and grant; reset has priority over flush.
- Full: gnt=0 for all requesters and rr_ptr holds. A release while full makes full=0 on the next cycle.
- Out-of-range rel_index is impossible by width (index < ENTRY_COUNT).

Decomposition:
- Package alloc_pkg holds:
  - localparam ENTRY_COUNT, IDX_W;
  - typedef entry_idx_t (logic [IDX_W-1:0]);
  - typedef busy_vec_t (logic [ENTRY_COUNT-1:0]).
- Sub-modules:
  - priority_encoder (existing) instantiated once.
  - rr_arbiter (NUM_REQ-wide round-robin with pointer input, winner output) as one new natural sub-module.

Test Plan:
- Reset, then req=4'b0001 for 3 cycles -> gnt=0001 with alloc_index 0, 1, 2 on successive cycles; free_count 64->61.
- req=4'b1111 held from rr_ptr=0 -> grants rotate 0001, 0010, 0100, 1000, 0001; indices increment 0..4.
- Allocate all 64 -> full=1, free_count=0, gnt=0 with req=1111. Then rel_valid with index 37 -> next cycle full=0, grant gives alloc_index=37.
- Same cycle: grant (to index 5) plus release of index 2 -> free_count unchanged; next cycle alloc_index=2.
- Release of already-free index 10 -> rel_err=1 and stays 1, busy unchanged. Flush with 20 busy -> next cycle free_count=64, alloc_index=0, and gnt=0 during the flush cycle.
- Assert rst_n=0 mid-stream with req=1111 -> gnt=0 in that cycle; afterwards busy=0, rr_ptr=0, rel_err=0, and the first grant goes to requester 0 with index 0.
